// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the RV32I pipeline and its hazard controller: stage status in,
// stage stall/flush controls, forwarding selects, error flag and perf counters out.
interface pipeline_hazard_ctrl_if #(
   parameter int IDX_W = 5,
   parameter int CNT_W = 32
);
   logic [IDX_W-1:0] id_rs1;
   logic [IDX_W-1:0] id_rs2;
   logic             id_use_rs1;
   logic             id_use_rs2;
   logic [IDX_W-1:0] ex_rs1;
   logic [IDX_W-1:0] ex_rs2;
   logic [IDX_W-1:0] ex_rd;
   logic             ex_reg_en;
   logic             ex_is_load;
   logic             ex_branch_taken;
   logic [IDX_W-1:0] mem_rd;
   logic             mem_reg_en;
   logic             mem_is_load;
   logic             mem_dm_req;
   logic             dm_ready;
   logic [IDX_W-1:0] wb_rd;
   logic             wb_reg_en;
   logic             im_ready;

   logic             pc_stall;
   logic             if_id_stall;
   logic             id_ex_stall;
   logic             ex_mem_stall;
   logic             mem_wb_stall;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic             ex_mem_flush;
   logic             id_fwd_rs1;
   logic             id_fwd_rs2;
   logic [1:0]       ex_fwd_rs1;
   logic [1:0]       ex_fwd_rs2;
   logic             dm_timeout_err;
   logic [CNT_W-1:0] perf_cycles;
   logic [CNT_W-1:0] perf_stall_cycles;
   logic [CNT_W-1:0] perf_flushes;
   logic             fetch_kill_dbg;

   // Memory handshake: mem_dm_req is held by the pipeline until the access completes;
   // dm_ready/im_ready are completion strobes, a word or write is accepted in any cycle
   // its ready is high and there is no backpressure on the returning data.
   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd, ex_reg_en,
             ex_is_load, ex_branch_taken, mem_rd, mem_reg_en, mem_is_load, mem_dm_req,
             dm_ready, wb_rd, wb_reg_en, im_ready,
      input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall, if_id_flush,
             id_ex_flush, ex_mem_flush, id_fwd_rs1, id_fwd_rs2, ex_fwd_rs1, ex_fwd_rs2,
             dm_timeout_err, perf_cycles, perf_stall_cycles, perf_flushes, fetch_kill_dbg
   );

   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd, ex_reg_en,
             ex_is_load, ex_branch_taken, mem_rd, mem_reg_en, mem_is_load, mem_dm_req,
             dm_ready, wb_rd, wb_reg_en, im_ready,
      output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall, if_id_flush,
             id_ex_flush, ex_mem_flush, id_fwd_rs1, id_fwd_rs2, ex_fwd_rs1, ex_fwd_rs2,
             dm_timeout_err, perf_cycles, perf_stall_cycles, perf_flushes, fetch_kill_dbg
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall/forwarding controller for a 5-stage RV32I pipeline with wait-state memories:
// priority-resolved stage controls, fetch-kill tracking, DM wait timeout and perf counters.
module pipeline_hazard_ctrl #(
   parameter int IDX_W      = 5,
   parameter int CNT_W      = 32,
   parameter int DM_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   pipeline_hazard_ctrl_if.slave hz
);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_KILL = 1'b1
   } fetch_state_e;

   localparam logic [15:0] TIMEOUT_LAST = 16'(DM_TIMEOUT - 1);

   fetch_state_e     state_q, state_d;
   logic [15:0]      wait_cnt_q, wait_cnt_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic dm_wait, timeout_hit, load_use, fetch_bubble, branch_acted;
   logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
   logic if_id_flush, id_ex_flush, ex_mem_flush;

   function automatic logic [1:0] ex_sel(input logic [IDX_W-1:0] rs,
                                         input logic             mem_en,
                                         input logic             mem_ld,
                                         input logic [IDX_W-1:0] mem_rd,
                                         input logic             wb_en,
                                         input logic [IDX_W-1:0] wb_rd);
      // A MEM-stage load has no data yet; that case is covered by the load-use stall.
      if (mem_en && !mem_ld && mem_rd != '0 && mem_rd == rs) return 2'd2;
      else if (wb_en && wb_rd != '0 && wb_rd == rs)           return 2'd1;
      else                                                    return 2'd0;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      if (en && v != '1) return v + {{(CNT_W-1){1'b0}}, 1'b1};
      else               return v;
   endfunction

   always_comb begin
      dm_wait      = hz.mem_dm_req && !hz.dm_ready;
      timeout_hit  = dm_wait && (wait_cnt_q == TIMEOUT_LAST);
      load_use     = hz.ex_is_load && hz.ex_reg_en && (hz.ex_rd != '0) &&
                     ((hz.id_use_rs1 && hz.ex_rd == hz.id_rs1) ||
                      (hz.id_use_rs2 && hz.ex_rd == hz.id_rs2));
      fetch_bubble = !hz.im_ready || (state_q == ST_KILL);
      branch_acted = hz.ex_branch_taken && !dm_wait;
   end

   always_comb begin
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      id_ex_stall  = 1'b0;
      ex_mem_stall = 1'b0;
      mem_wb_stall = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      if (dm_wait) begin
         // Frozen pipeline; on timeout the MEM access is dropped and MEM/WB takes a bubble.
         pc_stall     = 1'b1;
         if_id_stall  = 1'b1;
         id_ex_stall  = 1'b1;
         ex_mem_stall = 1'b1;
         mem_wb_stall = !timeout_hit;
         ex_mem_flush = timeout_hit;
      end else if (hz.ex_branch_taken) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (load_use) begin
         pc_stall    = 1'b1;
         if_id_stall = 1'b1;
         id_ex_flush = 1'b1;
      end else if (fetch_bubble) begin
         pc_stall    = !hz.im_ready;
         if_id_flush = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_RUN:  if (hz.ex_branch_taken && !hz.im_ready && !dm_wait) state_d = ST_KILL;
         ST_KILL: if (hz.im_ready && !hz.ex_branch_taken)             state_d = ST_RUN;
         default: state_d = ST_RUN;
      endcase
      wait_cnt_d  = (dm_wait && !timeout_hit) ? wait_cnt_q + 16'd1 : 16'd0;
      err_d       = err_q || timeout_hit;
      cyc_d       = sat_inc(cyc_q, 1'b1);
      stall_cnt_d = sat_inc(stall_cnt_q, pc_stall);
      flush_cnt_d = sat_inc(flush_cnt_q, branch_acted);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         wait_cnt_q  <= 16'd0;
         err_q       <= 1'b0;
         cyc_q       <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         err_q       <= err_d;
         cyc_q       <= cyc_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hz.pc_stall          = pc_stall;
   assign hz.if_id_stall       = if_id_stall;
   assign hz.id_ex_stall       = id_ex_stall;
   assign hz.ex_mem_stall      = ex_mem_stall;
   assign hz.mem_wb_stall      = mem_wb_stall;
   assign hz.if_id_flush       = if_id_flush;
   assign hz.id_ex_flush       = id_ex_flush;
   assign hz.ex_mem_flush      = ex_mem_flush;
   assign hz.id_fwd_rs1        = hz.wb_reg_en && (hz.wb_rd != '0) && (hz.wb_rd == hz.id_rs1);
   assign hz.id_fwd_rs2        = hz.wb_reg_en && (hz.wb_rd != '0) && (hz.wb_rd == hz.id_rs2);
   assign hz.ex_fwd_rs1        = ex_sel(hz.ex_rs1, hz.mem_reg_en, hz.mem_is_load, hz.mem_rd,
                                        hz.wb_reg_en, hz.wb_rd);
   assign hz.ex_fwd_rs2        = ex_sel(hz.ex_rs2, hz.mem_reg_en, hz.mem_is_load, hz.mem_rd,
                                        hz.wb_reg_en, hz.wb_rd);
   assign hz.dm_timeout_err    = err_q;
   assign hz.perf_cycles       = cyc_q;
   assign hz.perf_stall_cycles = stall_cnt_q;
   assign hz.perf_flushes      = flush_cnt_q;
   assign hz.fetch_kill_dbg    = (state_q == ST_KILL);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios then random traffic, each cycle's
// expected outputs come from a behavioural model and are checked by a separate monitor.
module tb_pipeline_hazard_ctrl;
  localparam int IDX_W      = 5;
  localparam int CNT_W      = 8;
  localparam int DM_TIMEOUT = 4;
  localparam int W          = 40;
  localparam int SAT        = (1 << CNT_W) - 1;

  typedef struct packed {
    logic             rst;
    logic [IDX_W-1:0] id_rs1;
    logic [IDX_W-1:0] id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [IDX_W-1:0] ex_rs1;
    logic [IDX_W-1:0] ex_rs2;
    logic [IDX_W-1:0] ex_rd;
    logic             ex_reg_en;
    logic             ex_is_load;
    logic             ex_branch_taken;
    logic [IDX_W-1:0] mem_rd;
    logic             mem_reg_en;
    logic             mem_is_load;
    logic             mem_dm_req;
    logic             dm_ready;
    logic [IDX_W-1:0] wb_rd;
    logic             wb_reg_en;
    logic             im_ready;
  } stim_t;

  typedef struct {
    bit kill;
    bit err;
    int wait_n;
    int cyc;
    int stl;
    int fls;
  } model_t;

  typedef enum {HZ_NONE, HZ_DM, HZ_BR, HZ_LU, HZ_FB} hazard_e;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) hz ();

  pipeline_hazard_ctrl #(.IDX_W(IDX_W), .CNT_W(CNT_W), .DM_TIMEOUT(DM_TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  model_t m, m_next;
  bit have_state = 1'b0;
  bit have_next  = 1'b0;

  // ---------------- reference model ----------------
  function automatic model_t reset_model();
    model_t r;
    r.kill = 1'b0; r.err = 1'b0; r.wait_n = 0; r.cyc = 0; r.stl = 0; r.fls = 0;
    return r;
  endfunction

  function automatic bit dm_waiting(stim_t s);
    return s.mem_dm_req && !s.dm_ready;
  endfunction

  function automatic bit timeout_now(model_t mm, stim_t s);
    return dm_waiting(s) && (mm.wait_n + 1 == DM_TIMEOUT);
  endfunction

  function automatic hazard_e winner(model_t mm, stim_t s);
    bit lu;
    lu = s.ex_is_load && s.ex_reg_en && s.ex_rd != 0 &&
         ((s.id_use_rs1 && s.ex_rd == s.id_rs1) || (s.id_use_rs2 && s.ex_rd == s.id_rs2));
    if (dm_waiting(s))              return HZ_DM;
    if (s.ex_branch_taken)          return HZ_BR;
    if (lu)                         return HZ_LU;
    if (!s.im_ready || mm.kill)     return HZ_FB;
    return HZ_NONE;
  endfunction

  // Youngest producer wins; a MEM load cannot supply data.
  function automatic logic [1:0] ex_src(stim_t s, logic [IDX_W-1:0] rs);
    if (rs == 0) return 2'd0;
    if (s.mem_reg_en && !s.mem_is_load && s.mem_rd == rs) return 2'd2;
    if (s.wb_reg_en && s.wb_rd == rs) return 2'd1;
    return 2'd0;
  endfunction

  // ctrl = {pc, if_id, id_ex, ex_mem, mem_wb stalls, if_id, id_ex, ex_mem flushes}
  function automatic logic [7:0] ctrl_of(model_t mm, stim_t s);
    case (winner(mm, s))
      HZ_DM:   return timeout_now(mm, s) ? 8'b11110_001 : 8'b11111_000;
      HZ_BR:   return 8'b00000_110;
      HZ_LU:   return 8'b11000_010;
      HZ_FB:   return {!s.im_ready, 4'b0000, 3'b100};
      default: return 8'b00000_000;
    endcase
  endfunction

  function automatic logic [W-1:0] model_out(model_t mm, stim_t s);
    logic [5:0] fwd;
    fwd[5]   = s.wb_reg_en && s.wb_rd != 0 && s.wb_rd == s.id_rs1;
    fwd[4]   = s.wb_reg_en && s.wb_rd != 0 && s.wb_rd == s.id_rs2;
    fwd[3:2] = ex_src(s, s.ex_rs1);
    fwd[1:0] = ex_src(s, s.ex_rs2);
    return {ctrl_of(mm, s), fwd, mm.err, mm.kill,
            CNT_W'(mm.cyc), CNT_W'(mm.stl), CNT_W'(mm.fls)};
  endfunction

  function automatic model_t model_adv(model_t mm, stim_t s);
    model_t r;
    logic [7:0] c;
    bit dw;
    r  = mm;
    c  = ctrl_of(mm, s);
    dw = dm_waiting(s);
    if (timeout_now(mm, s)) begin r.wait_n = 0; r.err = 1'b1; end
    else r.wait_n = dw ? mm.wait_n + 1 : 0;
    if (!mm.kill) r.kill = s.ex_branch_taken && !s.im_ready && !dw;
    else          r.kill = s.ex_branch_taken || !s.im_ready;
    r.cyc = (mm.cyc < SAT) ? mm.cyc + 1 : SAT;
    if (c[7] && mm.stl < SAT) r.stl = mm.stl + 1;
    if (s.ex_branch_taken && !dw && mm.fls < SAT) r.fls = mm.fls + 1;
    return r;
  endfunction

  // ---------------- driver ----------------
  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.dm_ready = 1'b1;
    s.im_ready = 1'b1;
    return s;
  endfunction

  task automatic apply(stim_t s);
    rst                = s.rst;
    hz.id_rs1          = s.id_rs1;
    hz.id_rs2          = s.id_rs2;
    hz.id_use_rs1      = s.id_use_rs1;
    hz.id_use_rs2      = s.id_use_rs2;
    hz.ex_rs1          = s.ex_rs1;
    hz.ex_rs2          = s.ex_rs2;
    hz.ex_rd           = s.ex_rd;
    hz.ex_reg_en       = s.ex_reg_en;
    hz.ex_is_load      = s.ex_is_load;
    hz.ex_branch_taken = s.ex_branch_taken;
    hz.mem_rd          = s.mem_rd;
    hz.mem_reg_en      = s.mem_reg_en;
    hz.mem_is_load     = s.mem_is_load;
    hz.mem_dm_req      = s.mem_dm_req;
    hz.dm_ready        = s.dm_ready;
    hz.wb_rd           = s.wb_rd;
    hz.wb_reg_en       = s.wb_reg_en;
    hz.im_ready        = s.im_ready;
  endtask

  task automatic step(stim_t s);
    @(posedge clk);
    #1;
    m          = m_next;
    have_state = have_next;
    apply(s);
    if (have_state) exp_q.push_back(model_out(m, s));
    if (s.rst) begin
      m_next    = reset_model();
      have_next = 1'b1;
    end else if (have_state) begin
      m_next = model_adv(m, s);
    end
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic [W-1:0] mon_exp, mon_got;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_got = {hz.pc_stall, hz.if_id_stall, hz.id_ex_stall, hz.ex_mem_stall, hz.mem_wb_stall,
                 hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush,
                 hz.id_fwd_rs1, hz.id_fwd_rs2, hz.ex_fwd_rs1, hz.ex_fwd_rs2,
                 hz.dm_timeout_err, hz.fetch_kill_dbg,
                 hz.perf_cycles, hz.perf_stall_cycles, hz.perf_flushes};
      check("stall_flush", 32'(mon_got[39:32]), 32'(mon_exp[39:32]));
      check("forwarding",  32'(mon_got[31:26]), 32'(mon_exp[31:26]));
      check("err_kill",    32'(mon_got[25:24]), 32'(mon_exp[25:24]));
      check("counters",    32'(mon_got[23:0]),  32'(mon_exp[23:0]));
    end
  end

  // ---------------- stimulus ----------------
  stim_t s;
  int    dm_hold;

  initial begin
    s = idle();
    s.rst = 1'b1;
    apply(s);
    repeat (2) step(s);
    s = idle();
    repeat (2) step(s);

    // ALU RAW: MEM and WB both produce x5, then MEM drops out, then all rd=0
    s = idle();
    s.ex_rs1 = 5'd5; s.mem_rd = 5'd5; s.mem_reg_en = 1'b1; s.wb_rd = 5'd5; s.wb_reg_en = 1'b1;
    s.id_rs1 = 5'd5;
    step(s);
    s.mem_reg_en = 1'b0;
    step(s);
    s.ex_rs1 = 5'd0; s.mem_rd = 5'd0; s.wb_rd = 5'd0; s.id_rs1 = 5'd0; s.mem_reg_en = 1'b1;
    step(s);

    // load-use on rs2 for one cycle
    s = idle();
    s.ex_is_load = 1'b1; s.ex_reg_en = 1'b1; s.ex_rd = 5'd7;
    s.id_rs2 = 5'd7; s.id_use_rs2 = 1'b1;
    step(s);
    s = idle();
    step(s);

    // branch together with load-use
    s = idle();
    s.ex_is_load = 1'b1; s.ex_reg_en = 1'b1; s.ex_rd = 5'd7;
    s.id_rs2 = 5'd7; s.id_use_rs2 = 1'b1; s.ex_branch_taken = 1'b1;
    step(s);
    s = idle();
    step(s);

    // DM wait for 3 cycles with a pending branch, then completion
    s = idle();
    s.mem_dm_req = 1'b1; s.dm_ready = 1'b0; s.ex_branch_taken = 1'b1;
    repeat (3) step(s);
    s.dm_ready = 1'b1;
    step(s);
    s = idle();
    step(s);

    // redirect during a pending fetch
    s = idle();
    s.im_ready = 1'b0; s.ex_branch_taken = 1'b1;
    step(s);
    s.ex_branch_taken = 1'b0;
    repeat (2) step(s);
    s.im_ready = 1'b1;
    step(s);
    s = idle();
    step(s);

    // DM timeout, sticky error, then reset mid-run
    s = idle();
    s.mem_dm_req = 1'b1; s.dm_ready = 1'b0;
    repeat (6) step(s);
    s = idle();
    repeat (2) step(s);
    s.rst = 1'b1;
    step(s);
    s.rst = 1'b0;
    repeat (2) step(s);

    // random traffic
    dm_hold = 0;
    for (int i = 0; i < 2500; i++) begin
      s = idle();
      s.rst             = ($urandom_range(0, 599) == 0);
      s.id_rs1          = 5'($urandom_range(0, 3));
      s.id_rs2          = 5'($urandom_range(0, 3));
      s.id_use_rs1      = 1'($urandom_range(0, 1));
      s.id_use_rs2      = 1'($urandom_range(0, 1));
      s.ex_rs1          = 5'($urandom_range(0, 3));
      s.ex_rs2          = 5'($urandom_range(0, 3));
      s.ex_rd           = 5'($urandom_range(0, 3));
      s.ex_reg_en       = 1'($urandom_range(0, 1));
      s.ex_is_load      = ($urandom_range(0, 3) == 0);
      s.ex_branch_taken = ($urandom_range(0, 5) == 0);
      s.mem_rd          = 5'($urandom_range(0, 3));
      s.mem_reg_en      = 1'($urandom_range(0, 1));
      s.mem_is_load     = ($urandom_range(0, 3) == 0);
      s.wb_rd           = 5'($urandom_range(0, 3));
      s.wb_reg_en       = 1'($urandom_range(0, 1));
      s.im_ready        = ($urandom_range(0, 3) != 0);
      if (dm_hold == 0 && $urandom_range(0, 39) == 0) dm_hold = $urandom_range(2, 7);
      if (dm_hold > 0) begin
        s.mem_dm_req = 1'b1;
        s.dm_ready   = 1'b0;
        dm_hold--;
      end else begin
        s.mem_dm_req = ($urandom_range(0, 2) == 0);
        s.dm_ready   = ($urandom_range(0, 3) != 0);
      end
      step(s);
    end

    s = idle();
    step(s);
    @(negedge clk);
    #1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain got=%0d pending expected=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard, stall and forwarding controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB), generalised to memories with wait states.
- Sits between the pipeline registers and the IM/DM ports.
- Produces per-stage stall/flush controls, ID and EX forwarding selects, a fetch-kill tracker for redirects during pending fetches, a DM wait-timeout error, and saturating performance counters.

Parameters:
IDX_W, 5, register index width
CNT_W, 32, perf counter width
DM_TIMEOUT, 255, max consecutive DM wait cycles before error (1..2^16-1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_rs1, id_rs2  in  IDX_W  ID-stage source indices
id_use_rs1, id_use_rs2  in  1  ID instruction reads rs1/rs2
ex_rs1, ex_rs2  in  IDX_W  EX-stage source indices
ex_rd  in  IDX_W  EX destination
ex_reg_en  in  1  EX writes regfile
ex_is_load  in  1  EX is load
ex_branch_taken  in  1  EX redirect (jump or taken branch)
mem_rd  in  IDX_W  MEM destination
mem_reg_en  in  1  MEM writes regfile
mem_is_load  in  1  MEM is load
mem_dm_req  in  1  MEM stage accessing DM (load or store)
dm_ready  in  1  DM completes access this cycle
wb_rd  in  IDX_W  WB destination
wb_reg_en  in  1  WB writes regfile
im_ready  in  1  IM returns valid instruction this cycle
pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall  out  1  hold stage register
if_id_flush, id_ex_flush, ex_mem_flush  out  1  load bubble into stage register
id_fwd_rs1, id_fwd_rs2  out  1  0=regfile, 1=WB data
ex_fwd_rs1, ex_fwd_rs2  out  2  0=ID/EX data, 1=WB, 2=MEM ALU result, 3 unused
dm_timeout_err  out  1  sticky error
perf_cycles, perf_stall_cycles, perf_flushes  out  CNT_W  counters

Behaviour:
- Reset: fetch FSM goes to RUN, wait counter 0, dm_timeout_err 0, all counters 0.
- Stall/flush outputs are combinational. With no hazard they are all 0.

Forwarding (combinational):
- EX select = 2 if mem_reg_en && mem_rd!=0 && mem_rd==ex_rsN && !mem_is_load.
- Else EX select = 1 if wb_reg_en && wb_rd!=0 && wb_rd==ex_rsN.
- Else EX select = 0.
- id_fwd_rsN = wb_reg_en && wb_rd!=0 && wb_rd==id_rsN.

Hazard sources:
- dm_wait = mem_dm_req && !dm_ready.
- load_use = ex_is_load && ex_reg_en && ex_rd!=0 && ((id_use_rs1 && ex_rd==id_rs1) || (id_use_rs2 && ex_rd==id_rs2)).
- fetch_bubble = !im_ready || state==KILL.

Priority (highest first):
1. dm_wait: all five stall outputs = 1, all flush outputs = 0. Redirect and load_use are ignored that cycle; the pipeline is frozen, so they re-present next cycle.
2. ex_branch_taken: if_id_flush=1, id_ex_flush=1, pc_stall=0 (PC loads target). load_use is ignored.
3. load_use: pc_stall=1, if_id_stall=1, id_ex_flush=1.
4. fetch_bubble: pc_stall = !im_ready, if_id_flush=1. Downstream stages advance.
- ex_mem_flush is asserted only by the timeout abort (below).

Fetch FSM {RUN, KILL}:
- RUN→KILL: ex_branch_taken && !im_ready && !dm_wait. The in-flight fetch is stale.
- KILL→RUN: when im_ready. The returning word is discarded via if_id_flush, and pc_stall=0 so the fetch restarts at the target.
- ex_branch_taken again in KILL: remain in KILL.

DM timeout:
- 16-bit wait counter increments each dm_wait cycle and clears otherwise.
- When the counter reaches DM_TIMEOUT while dm_wait holds:
  - dm_timeout_err is set (sticky until rst);
  - ex_mem_flush=1 and mem_wb_stall=0 that cycle, aborting the access (the MEM instruction becomes a bubble);
  - the counter clears.

Counters (saturate at all-ones, no wrap):
- perf_cycles: +1 every cycle.
- perf_stall_cycles: +1 when pc_stall.
- perf_flushes: +1 when ex_branch_taken is acted on.
- rst mid-operation clears everything in the same edge. Outputs are valid the cycle after rst deasserts.

Test Plan:
- ALU RAW: MEM rd=5 ALU, EX rs1=5, WB rd=5 also → ex_fwd_rs1=2; drop mem_reg_en → 1; rd=0 everywhere → 0.
- Load-use: EX lw x7, ID add rs2=7 (id_use_rs2=1), im_ready=1 → pc_stall=1, if_id_stall=1, id_ex_flush=1 for exactly 1 cycle; perf_stall_cycles +1.
- Branch plus load_use in the same cycle → if_id_flush=1, id_ex_flush=1, pc_stall=0; perf_flushes=1.
- DM wait: mem_dm_req=1, dm_ready=0 for 3 cycles, with ex_branch_taken=1 → all stalls=1 and no flushes for 3 cycles. Next cycle with dm_ready=1 → branch flush acted on.
- Kill: im_ready=0, branch taken → state KILL. im_ready=0 for 2 cycles then 1 → if_id_flush on the arrival cycle, state RUN after.
- Timeout: DM_TIMEOUT=4, dm_ready held 0 → ex_mem_flush=1 and dm_timeout_err=1 on the 4th wait cycle. Error stays 1 until rst=1, then all outputs and counters = 0.
